glitch_sweep_sched: RTL

- Schedules glitch attempts on the 1.2V DAC and owns the DAC output. It sits between pmic_core's dac_out and the DAC pins.
- On each trigger from the core, it waits a programmed delay, then drives a glitch code for a programmed width, then restores the core's value.
- Between attempts it sweeps the delay and width over configured ranges and stops on success, attempt limit or sweep completion.

---
 rtl/glitch_sweep_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/glitch_sweep_sched.sv
// Glitch scheduler: after each core trigger it waits a delay, drives a glitch code on the DAC
// for a width, then sweeps delay (inner) and width (outer) until success, limit or sweep end.
module glitch_sweep_sched #(
    parameter int DAC_W = 8,
    parameter int DLY_W = 32,
    parameter int WID_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             trigger,
    input  logic             success,
    input  logic [DAC_W-1:0] core_dac,
    input  logic [DAC_W-1:0] glitch_code,
    input  logic [DLY_W-1:0] delay_start,
    input  logic [DLY_W-1:0] delay_step,
    input  logic [DLY_W-1:0] delay_end,
    input  logic [WID_W-1:0] width_start,
    input  logic [WID_W-1:0] width_step,
    input  logic [WID_W-1:0] width_end,
    input  logic [WID_W-1:0] cooldown,
    input  logic [CNT_W-1:0] max_attempts,
    output logic [DAC_W-1:0] dac_out,
    output logic             busy,
    output logic             glitching,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] attempt_count,
    output logic [DLY_W-1:0] cur_delay,
    output logic [WID_W-1:0] cur_width
);
    localparam int CW = (DLY_W > WID_W) ? DLY_W : WID_W;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_DELAY, S_GLITCH, S_COOLDOWN, S_ADVANCE, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [CW-1:0]    r_cnt;
    logic [DAC_W-1:0] r_dac;
    logic             r_glitching;
    logic             r_busy;
    logic             r_done;
    logic             r_hit;
    logic [CNT_W-1:0] r_attempts;
    logic [DLY_W-1:0] r_cur_delay;
    logic [WID_W-1:0] r_cur_width;

    logic [DAC_W-1:0] r_code;
    logic [DLY_W-1:0] r_dly_start;
    logic [DLY_W-1:0] r_dly_step;
    logic [DLY_W-1:0] r_dly_end;
    logic [WID_W-1:0] r_wid_start;
    logic [WID_W-1:0] r_wid_step;
    logic [WID_W-1:0] r_wid_end;
    logic [WID_W-1:0] r_cool;
    logic [CNT_W-1:0] r_max;

    logic [DLY_W:0]   w_dly_sum;
    logic [WID_W:0]   w_wid_sum;
    logic [CNT_W-1:0] w_att_inc;
    logic             w_dly_wrap;
    logic             w_wid_over;
    logic             w_max_reached;
    logic [CW-1:0]    w_dly_last;
    logic [CW-1:0]    w_wid_last;
    logic [CW-1:0]    w_cool_last;
    logic             w_glitch_now;

    // Sums carry one extra bit so a step past the top of the range counts as an overrun.
    assign w_dly_sum     = {1'b0, r_cur_delay} + {1'b0, r_dly_step};
    assign w_wid_sum     = {1'b0, r_cur_width} + {1'b0, r_wid_step};
    assign w_dly_wrap    = w_dly_sum[DLY_W] || (w_dly_sum[DLY_W-1:0] > r_dly_end);
    assign w_wid_over    = w_wid_sum[WID_W] || (w_wid_sum[WID_W-1:0] > r_wid_end);
    assign w_att_inc     = r_attempts + CNT_W'(1);
    assign w_max_reached = (r_max != '0) && (w_att_inc == r_max);
    assign w_dly_last    = CW'(r_cur_delay) - CW'(1);
    assign w_wid_last    = (r_cur_width == '0) ? '0 : (CW'(r_cur_width) - CW'(1));
    assign w_cool_last   = CW'(r_cool) - CW'(1);
    assign w_glitch_now  = (r_state == S_GLITCH) && enable;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE: if (enable) w_nxt = S_ARM;
            S_ARM: begin
                if (!enable)      w_nxt = S_IDLE;
                else if (trigger) w_nxt = (r_cur_delay == '0) ? S_GLITCH : S_DELAY;
            end
            S_DELAY: begin
                if (!enable)                  w_nxt = S_IDLE;
                else if (r_cnt == w_dly_last) w_nxt = S_GLITCH;
            end
            S_GLITCH: begin
                if (!enable)                  w_nxt = S_IDLE;
                else if (r_cnt == w_wid_last) w_nxt = (r_cool == '0) ? S_ADVANCE : S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (!enable)                   w_nxt = S_IDLE;
                else if (r_cnt == w_cool_last) w_nxt = S_ADVANCE;
            end
            S_ADVANCE: begin
                if (!enable)
                    w_nxt = S_IDLE;
                else if (r_hit || w_max_reached || (w_dly_wrap && w_wid_over))
                    w_nxt = S_DONE;
                else
                    w_nxt = S_ARM;
            end
            S_DONE: if (!enable) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Campaign configuration is frozen at start; changes while running are ignored.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && enable) begin
            r_code      <= glitch_code;
            r_dly_start <= delay_start;
            r_dly_step  <= delay_step;
            r_dly_end   <= delay_end;
            r_wid_start <= width_start;
            r_wid_step  <= width_step;
            r_wid_end   <= width_end;
            r_cool      <= cooldown;
            r_max       <= max_attempts;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dac       <= '0;
            r_glitching <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_attempts  <= '0;
            r_cur_delay <= '0;
            r_cur_width <= '0;
        end else begin
            r_state     <= w_nxt;
            r_busy      <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
            r_done      <= (w_nxt == S_DONE);
            r_dac       <= w_glitch_now ? r_code : core_dac;
            r_glitching <= w_glitch_now;
            r_cnt       <= (w_nxt == r_state) ? (r_cnt + CW'(1)) : '0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_cur_delay <= delay_start;
                        r_cur_width <= width_start;
                        r_attempts  <= '0;
                        r_hit       <= 1'b0;
                    end
                end
                S_GLITCH, S_COOLDOWN: begin
                    if (enable && success) r_hit <= 1'b1;
                end
                S_ADVANCE: begin
                    if (enable) begin
                        r_attempts <= w_att_inc;
                        // A hit or the attempt limit freezes the parameters of the final attempt.
                        if (!r_hit && !w_max_reached) begin
                            if (w_dly_wrap) begin
                                r_cur_delay <= r_dly_start;
                                if (!w_wid_over) r_cur_width <= w_wid_sum[WID_W-1:0];
                            end else begin
                                r_cur_delay <= w_dly_sum[DLY_W-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dac_out       = r_dac;
    assign glitching     = r_glitching;
    assign busy          = r_busy;
    assign done          = r_done;
    assign hit           = r_hit;
    assign attempt_count = r_attempts;
    assign cur_delay     = r_cur_delay;
    assign cur_width     = r_cur_width;
endmodule
